// File: rtl/imem_boot_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : source bytes packed into one instruction word
//   WORD_W         : instruction word width in bits
// ---------------------------------------------------------------------------
package imem_boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
// Collects bytes little-endian into an instruction word.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : discard any partial word and restart at byte 0
//   byte_en     : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word        : assembled word; valid while word_full is high
//   word_full   : the byte consumed this cycle completes the word
// The last byte is merged combinationally so the consumer can register the
// full word on the same edge that accepts the final byte.
// ---------------------------------------------------------------------------
module imem_word_packer
    import imem_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam int SH_W  = WORD_W - 8;

    logic [IDX_W-1:0] byte_idx_r;
    logic [SH_W-1:0]  shift_r;

    // Byte counter and shift register; newest byte enters at the top so the
    // first byte ends up in the least significant lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_r <= '0;
            shift_r    <= '0;
        end else if (clear) begin
            byte_idx_r <= '0;
            shift_r    <= '0;
        end else if (byte_en) begin
            byte_idx_r <= byte_idx_r + IDX_W'(1);
            shift_r    <= {byte_data, shift_r[SH_W-1:8]};
        end
    end

    assign word      = {byte_data, shift_r};
    assign word_full = byte_en && (byte_idx_r == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Fills instruction memory from a byte stream and holds the core in reset
// until a complete, in-range program has been written.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load_start, load_len  : start pulse and program length in words
//   byte_valid, byte_data : byte source; byte_ready is the accept handshake
//   mem_we/waddr/wdata    : imem write port (byte address, word aligned)
//   core_rst_n            : core reset, released only on successful load
//   busy, done, err       : load status
//   checksum              : XOR of all words written by the current load
// ---------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      checksum
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MEM_DEPTH);

    state_t            state_r;
    logic [LEN_W-1:0]  idx_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx_next_s;
    logic [29:0]       idx_ext_s;
    logic [31:0]       waddr_s;
    logic              clear_s;
    logic              byte_en_s;
    logic [WORD_W-1:0] word_s;
    logic              word_full_s;

    // A start pulse is honoured only when no load is in flight.
    always_comb begin
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: clear_s = load_start;
            default:                  clear_s = 1'b0;
        endcase
    end

    assign byte_en_s  = byte_valid && byte_ready && (state_r == ST_RECV);
    assign idx_next_s = idx_r + LEN_W'(1);
    assign idx_ext_s  = 30'(idx_r);
    assign waddr_s    = BASE_ADDR + {idx_ext_s, 2'b00};

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .byte_en   (byte_en_s),
        .byte_data (byte_data),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            len_r      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (load_start) begin
                        idx_r    <= '0;
                        len_r    <= load_len;
                        mem_we   <= 1'b0;
                        checksum <= 32'h0000_0000;
                        if (load_len == LEN_W'(0)) begin
                            // Empty program: nothing to write, release at once.
                            state_r    <= ST_DONE;
                            byte_ready <= 1'b0;
                            core_rst_n <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            err        <= 1'b0;
                        end else if (load_len > DEPTH_L) begin
                            state_r    <= ST_ERR;
                            byte_ready <= 1'b0;
                            core_rst_n <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state_r    <= ST_RECV;
                            byte_ready <= 1'b1;
                            core_rst_n <= 1'b0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_full_s) begin
                        state_r    <= ST_WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_waddr  <= waddr_s;
                        mem_wdata  <= word_s;
                    end
                end
                ST_WRITE: begin
                    mem_we   <= 1'b0;
                    checksum <= checksum ^ mem_wdata;
                    idx_r    <= idx_next_s;
                    if (idx_next_s == len_r) begin
                        state_r    <= ST_DONE;
                        byte_ready <= 1'b0;
                        core_rst_n <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        state_r    <= ST_RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    core_rst_n <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed bench for imem_boot_loader (MEM_DEPTH=256, BASE_ADDR=0, LEN_W=9).
// Inputs change 1 ns after the rising edge; outputs are sampled there or on
// the falling edge, never at the active edge.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    int          wr_total = 0;

    logic [31:0] prog [0:4];

    always #5 clk = ~clk;

    imem_boot_loader #(
        .MEM_DEPTH (256),
        .BASE_ADDR (32'h0000_0000),
        .LEN_W     (9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    // Edge counter used to time writes against byte acceptance.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every write pulse seen on the imem port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] <= mem_waddr;
                wr_data[wr_total] <= mem_wdata;
                wr_cyc[wr_total]  <= cyc;
            end
            wr_total <= wr_total + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] len);
        load_len   = len;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Offer one byte until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b, output int acc);
        bit taken;
        taken      = 1'b0;
        acc        = -1;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !taken; t++) begin
            if (byte_ready === 1'b1) begin
                acc   = cyc;
                taken = 1'b1;
            end
            step();
        end
        byte_valid = 1'b0;
        vectors++;
        if (!taken) begin
            miscompares++;
            $display("FAIL byte_accept: byte %h not accepted, required acceptance within 40 cycles", b);
        end
    endtask

    // Send one word little-endian, idling 'gap' cycles after each byte.
    task automatic send_word(input logic [31:0] w, input int gap, output int acc0);
        int acc;
        acc0 = -1;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], acc);
            if (k == 0) acc0 = acc;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20 && done !== 1'b1; t++) step();
    endtask

    task automatic check_reset_values(input string tag);
        if (core_rst_n !== 1'b0) begin miscompares++; $display("FAIL %s core_rst_n: got %b want 0", tag, core_rst_n); end
        vectors++;
        if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL %s byte_ready: got %b want 0", tag, byte_ready); end
        vectors++;
        if (mem_we !== 1'b0) begin miscompares++; $display("FAIL %s mem_we: got %b want 0", tag, mem_we); end
        vectors++;
        if (mem_waddr !== 32'h0) begin miscompares++; $display("FAIL %s mem_waddr: got %h want 0", tag, mem_waddr); end
        vectors++;
        if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL %s mem_wdata: got %h want 0", tag, mem_wdata); end
        vectors++;
        if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL %s busy/done/err: got %b want 000", tag, {busy, done, err}); end
        vectors++;
        if (checksum !== 32'h0) begin miscompares++; $display("FAIL %s checksum: got %h want 0", tag, checksum); end
        vectors++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_len   = 9'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
    endtask

    // Load the five-word program; gap=0 for streaming, gap>0 for backpressure.
    task automatic load_program(input string tag, input int gap, input bit check_timing);
        int base;
        int acc0;
        int a;
        base = wr_total;
        for (int w = 0; w < 5; w++) begin
            send_word(prog[w], gap, a);
            if (w == 0) acc0 = a;
        end
        wait_done();
        step();
        if (wr_total - base !== 5) begin miscompares++; $display("FAIL %s write_count: got %0d want 5", tag, wr_total - base); end
        vectors++;
        for (int w = 0; w < 5; w++) begin
            if (wr_addr[base + w] !== 32'(4 * w)) begin
                miscompares++;
                $display("FAIL %s waddr[%0d]: got %h want %h", tag, w, wr_addr[base + w], 32'(4 * w));
            end
            vectors++;
            if (wr_data[base + w] !== prog[w]) begin
                miscompares++;
                $display("FAIL %s wdata[%0d]: got %h want %h", tag, w, wr_data[base + w], prog[w]);
            end
            vectors++;
        end
        if ({done, core_rst_n, busy} !== 3'b110) begin miscompares++; $display("FAIL %s done/core_rst_n/busy: got %b want 110", tag, {done, core_rst_n, busy}); end
        vectors++;
        if (checksum !== 32'h08E0A273) begin miscompares++; $display("FAIL %s checksum: got %h want 08e0a273", tag, checksum); end
        vectors++;
        if (mem_waddr !== 32'h10 || mem_wdata !== 32'h63) begin
            miscompares++;
            $display("FAIL %s hold_addr_data: got %h/%h want 00000010/00000063", tag, mem_waddr, mem_wdata);
        end
        vectors++;
        if (check_timing) begin
            // Accept cycle plus three more accept cycles, write in the fifth.
            if (wr_cyc[base] !== acc0 + 4) begin miscompares++; $display("FAIL %s first_write_cycle: got %0d want %0d", tag, wr_cyc[base], acc0 + 4); end
            vectors++;
            if (wr_cyc[base + 1] !== wr_cyc[base] + 5) begin miscompares++; $display("FAIL %s word_period: got %0d want %0d", tag, wr_cyc[base + 1] - wr_cyc[base], 5); end
            vectors++;
        end
    endtask

    task automatic test_nominal();
        pulse_start(9'd5);
        if ({busy, byte_ready, core_rst_n} !== 3'b110) begin miscompares++; $display("FAIL nominal_start busy/ready/core_rst_n: got %b want 110", {busy, byte_ready, core_rst_n}); end
        vectors++;
        load_program("nominal", 0, 1'b1);
    endtask

    task automatic test_reload_from_done();
        pulse_start(9'd5);
        if ({core_rst_n, done, busy} !== 3'b001) begin miscompares++; $display("FAIL reload core_rst_n/done/busy: got %b want 001", {core_rst_n, done, busy}); end
        vectors++;
        if (checksum !== 32'h0) begin miscompares++; $display("FAIL reload checksum: got %h want 0", checksum); end
        vectors++;
    endtask

    task automatic test_backpressure();
        load_program("gaps", 3, 1'b0);
    endtask

    task automatic test_length_error();
        int  base;
        int  a;
        bit  saw_ready;
        base = wr_total;
        pulse_start(9'd257);
        if ({err, core_rst_n, busy, done} !== 4'b1000) begin miscompares++; $display("FAIL lenerr status err/core/busy/done: got %b want 1000", {err, core_rst_n, busy, done}); end
        vectors++;
        saw_ready  = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int t = 0; t < 6; t++) begin
            if (byte_ready !== 1'b0) saw_ready = 1'b1;
            step();
        end
        byte_valid = 1'b0;
        if (saw_ready) begin miscompares++; $display("FAIL lenerr byte_ready: got 1 want 0 throughout"); end
        vectors++;
        if (wr_total !== base) begin miscompares++; $display("FAIL lenerr writes: got %0d want 0", wr_total - base); end
        vectors++;
        pulse_start(9'd1);
        send_word(32'h0000_0013, 0, a);
        wait_done();
        step();
        if (wr_total - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h13) begin
            miscompares++;
            $display("FAIL lenerr_recover write: got n=%0d %h/%h want 1 00000000/00000013", wr_total - base, wr_addr[base], wr_data[base]);
        end
        vectors++;
        if ({done, err, core_rst_n} !== 3'b101) begin miscompares++; $display("FAIL lenerr_recover done/err/core: got %b want 101", {done, err, core_rst_n}); end
        vectors++;
    endtask

    task automatic test_ignored_start();
        int base;
        int a;
        base = wr_total;
        pulse_start(9'd2);
        send_byte(8'h11, a);
        send_byte(8'h22, a);
        pulse_start(9'd0);
        if ({busy, done, byte_ready} !== 3'b101) begin miscompares++; $display("FAIL ignored_start busy/done/ready: got %b want 101", {busy, done, byte_ready}); end
        vectors++;
        send_byte(8'h33, a);
        send_byte(8'h44, a);
        send_word(32'h8877_6655, 0, a);
        wait_done();
        step();
        if (wr_total - base !== 2) begin miscompares++; $display("FAIL ignored_start write_count: got %0d want 2", wr_total - base); end
        vectors++;
        if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h4433_2211) begin miscompares++; $display("FAIL ignored_start word0: got %h/%h want 00000000/44332211", wr_addr[base], wr_data[base]); end
        vectors++;
        if (wr_addr[base + 1] !== 32'h4 || wr_data[base + 1] !== 32'h8877_6655) begin miscompares++; $display("FAIL ignored_start word1: got %h/%h want 00000004/88776655", wr_addr[base + 1], wr_data[base + 1]); end
        vectors++;
        if (checksum !== 32'hCC44_4444 || done !== 1'b1) begin miscompares++; $display("FAIL ignored_start checksum/done: got %h/%b want cc444444/1", checksum, done); end
        vectors++;
    endtask

    task automatic test_reset_mid_load();
        int  base;
        int  a;
        bit  saw_ready;
        pulse_start(9'd3);
        send_word(prog[0], 0, a);
        send_byte(8'h03, a);
        send_byte(8'h21, a);
        rst_n = 1'b0;
        step();
        check_reset_values("midreset");
        rst_n      = 1'b1;
        base       = wr_total;
        saw_ready  = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        for (int t = 0; t < 8; t++) begin
            step();
            if (byte_ready !== 1'b0) saw_ready = 1'b1;
        end
        byte_valid = 1'b0;
        if (saw_ready || wr_total !== base) begin miscompares++; $display("FAIL midreset idle: got ready_seen=%b writes=%0d want 0/0", saw_ready, wr_total - base); end
        vectors++;
        pulse_start(9'd1);
        send_word(32'hD4C3_B2A1, 0, a);
        wait_done();
        step();
        if (wr_total - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hD4C3_B2A1) begin
            miscompares++;
            $display("FAIL midreset fresh_load: got n=%0d %h/%h want 1 00000000/d4c3b2a1", wr_total - base, wr_addr[base], wr_data[base]);
        end
        vectors++;
        if (checksum !== 32'hD4C3_B2A1 || done !== 1'b1) begin miscompares++; $display("FAIL midreset checksum/done: got %h/%b want d4c3b2a1/1", checksum, done); end
        vectors++;
    endtask

    task automatic test_zero_length();
        int base;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        if (done !== 1'b0) begin miscompares++; $display("FAIL zero_len pre done: got %b want 0", done); end
        vectors++;
        base = wr_total;
        pulse_start(9'd0);
        if ({done, core_rst_n, busy, err, byte_ready} !== 5'b11000) begin
            miscompares++;
            $display("FAIL zero_len status done/core/busy/err/ready: got %b want 11000", {done, core_rst_n, busy, err, byte_ready});
        end
        vectors++;
        step();
        step();
        if (wr_total !== base) begin miscompares++; $display("FAIL zero_len writes: got %0d want 0", wr_total - base); end
        vectors++;
    endtask

    initial begin
        prog[0] = 32'h0800_2083;
        prog[1] = 32'h0840_2103;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0880_2223;
        prog[4] = 32'h0000_0063;

        test_reset();
        test_nominal();
        test_reload_from_done();
        test_backpressure();
        test_length_error();
        test_ignored_start();
        test_reset_mid_load();
        test_zero_length();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
